spart_driver: RTL

Bus-master sequencer for the mini-SPART register interface. After reset it programs the 16-bit baud divisor from a 2-bit baud selector, then polls the SPART status register. It moves received bytes to a user-side valid pulse and drains a one-entry user transmit buffer into the SPART transmit register. It sits between user logic and the SPART `iocs`/`iorw`/`ioaddr`/databus port and is the only master on that port.

---
 rtl/spart_pkg.sv | 33 +++
 rtl/spart_tx_slot.sv | 25 ++
 rtl/spart_driver.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/spart_pkg.sv
// spart_pkg: shared codes, state enum and divisor helper for spart_driver.
// The WR_EC state is only reachable when SPART_DRV_ECHO_EN is defined.
package spart_pkg;

  localparam logic [1:0] A_BUF  = 2'b00;
  localparam logic [1:0] A_STAT = 2'b01;
  localparam logic [1:0] A_DBL  = 2'b10;
  localparam logic [1:0] A_DBH  = 2'b11;

  localparam int TBR_BIT = 0;
  localparam int RDA_BIT = 1;

  typedef enum logic [2:0] {
    S_INIT,
    S_WR_DBL,
    S_WR_DBH,
    S_POLL,
    S_RD_RX,
    S_WR_TX,
    S_WR_EC
  } state_t;

  // sel 0..3 selects 4800 << sel baud; result truncates before the -1
  function automatic logic [15:0] baud_div(
    input int unsigned clk_hz,
    input logic [1:0]  sel
  );
    int unsigned baud;
    baud = 32'd4800 << sel;
    return 16'(clk_hz / (16 * baud) - 1);
  endfunction

endpackage

// File: rtl/spart_tx_slot.sv
// spart_tx_slot: one-entry byte buffer; a drain beats a load in the
// same cycle.
module spart_tx_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       drain,
  input  logic [7:0] din,
  output logic       full,
  output logic [7:0] dout
);

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      dout <= 8'h00;
    end else if (drain) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end
  end

endmodule

// File: rtl/spart_driver.sv
// spart_driver: bus-master sequencer for the mini-SPART register port.
// Define SPART_DRV_ECHO_EN to echo every received byte back out.
module spart_driver #(
  parameter int unsigned CLK_HZ = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  output logic [7:0] databus_wr,
  input  logic [7:0] databus_rd,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       cfg_done
);

  import spart_pkg::*;

  state_t      state;
  state_t      nxt;
  logic [1:0]  cfg_q;
  logic [15:0] div;
  logic        tx_full;
  logic [7:0]  tx_byte;
  logic        ec_full;
  logic [7:0]  ec_data;

  always_comb div = baud_div(CLK_HZ, cfg_q);

  assign tx_ready = !tx_full;

  spart_tx_slot u_tx (
    .clk   (clk),
    .rst   (rst),
    .load  (tx_valid && tx_ready),
    .drain (state == S_WR_TX),
    .din   (tx_data),
    .full  (tx_full),
    .dout  (tx_byte)
  );

`ifdef SPART_DRV_ECHO_EN
  spart_tx_slot u_echo (
    .clk   (clk),
    .rst   (rst),
    .load  (state == S_RD_RX),
    .drain (state == S_WR_EC),
    .din   (databus_rd),
    .full  (ec_full),
    .dout  (ec_data)
  );
`else
  assign ec_full = 1'b0;
  assign ec_data = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= nxt;
  end

  // a pending echo also blocks RX so the echo slot never overflows
  always_comb begin
    nxt = state;
    unique case (state)
      S_INIT:   nxt = S_WR_DBL;
      S_WR_DBL: nxt = S_WR_DBH;
      S_WR_DBH: nxt = S_POLL;
      S_POLL: begin
        if (br_cfg != cfg_q)
          nxt = S_INIT;
        else if (ec_full && databus_rd[TBR_BIT])
          nxt = S_WR_EC;
        else if (databus_rd[RDA_BIT] && !ec_full)
          nxt = S_RD_RX;
        else if (databus_rd[TBR_BIT] && tx_full)
          nxt = S_WR_TX;
      end
      S_RD_RX, S_WR_TX, S_WR_EC: nxt = S_POLL;
      default: nxt = S_INIT;
    endcase
  end

  always_comb begin
    iocs       = 1'b0;
    iorw       = 1'b1;
    ioaddr     = A_BUF;
    databus_wr = 8'h00;
    unique case (state)
      S_WR_DBL: begin
        iocs       = 1'b1;
        iorw       = 1'b0;
        ioaddr     = A_DBL;
        databus_wr = div[7:0];
      end
      S_WR_DBH: begin
        iocs       = 1'b1;
        iorw       = 1'b0;
        ioaddr     = A_DBH;
        databus_wr = div[15:8];
      end
      S_POLL: begin
        iocs   = 1'b1;
        ioaddr = A_STAT;
      end
      S_RD_RX: iocs = 1'b1;
      S_WR_TX: begin
        iocs       = 1'b1;
        iorw       = 1'b0;
        databus_wr = tx_byte;
      end
      S_WR_EC: begin
        iocs       = 1'b1;
        iorw       = 1'b0;
        databus_wr = ec_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                 cfg_q <= 2'b00;
    else if (state == S_INIT) cfg_q <= br_cfg;
  end

  always_ff @(posedge clk) begin
    if (rst)                   cfg_done <= 1'b0;
    else if (nxt == S_INIT)    cfg_done <= 1'b0;
    else if (state == S_WR_DBH) cfg_done <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
    end else begin
      rx_valid <= (state == S_RD_RX);
      if (state == S_RD_RX) rx_data <= databus_rd;
    end
  end

endmodule
